// File: rtl/sm3_msg_expand.sv
// SM3 message expander: takes one 512-bit padded block and streams W_j / W'_j
// for j = 0..63 on a valid/ready interface, one pair per accepted beat.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a block; blk_ready high, no pair on the output
// RUN   | window holds W_j..W_{j+15}; pair j presented until accepted
module sm3_msg_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_j,
    output logic [31:0]  wp_j,
    output logic [5:0]   w_idx,
    output logic         w_last,
    output logic         busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_new;

    function automatic logic [31:0] rotl7(input logic [31:0] x);
        return {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] rotl15(input logic [31:0] x);
        return {x[16:0], x[31:17]};
    endfunction

    function automatic logic [31:0] rotl23(input logic [31:0] x);
        return {x[8:0], x[31:9]};
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl15(x) ^ rotl23(x);
    endfunction

    // W_{j+16}; keeps running past j = 51, those words are never presented
    assign w_new = p1(win_q[0] ^ win_q[7] ^ rotl15(win_q[13])) ^ rotl7(win_q[3]) ^ win_q[10];

    assign blk_ready = (state_q == IDLE);
    assign w_valid   = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign w_j       = win_q[0];
    assign wp_j      = win_q[0] ^ win_q[4];
    assign w_idx     = cnt_q;
    assign w_last    = (state_q == RUN) && (cnt_q == 6'd63);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = blk_data[511 - 32*i -: 32];
                    end
                    cnt_d   = 6'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[15] = w_new;
                    cnt_d     = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Self-checking bench for sm3_msg_expand: known-answer table for "abc",
// back-pressure, back-to-back, mid-block reset, edge data and random blocks.
module tb_sm3_msg_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_j;
    logic [31:0]  wp_j;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         busy;

    int tests = 0;
    int fails = 0;

    typedef logic [31:0] warr_t [64];
    typedef struct {
        int          j;
        bit          chk_w;
        logic [31:0] w;
        bit          chk_wp;
        logic [31:0] wp;
    } kat_t;

    sm3_msg_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_j       (w_j),
        .wp_j      (wp_j),
        .w_idx     (w_idx),
        .w_last    (w_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1f(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    // Reference SM3 expansion, written directly from the recurrence on W_n.
    function automatic void model(input logic [511:0] b, output warr_t w, output warr_t wp);
        logic [31:0] e [68];
        for (int i = 0; i < 16; i++) e[i] = b[511 - 32*i -: 32];
        for (int n = 16; n < 68; n++)
            e[n] = p1f(e[n-16] ^ e[n-9] ^ rol(e[n-3], 15)) ^ rol(e[n-13], 7) ^ e[n-6];
        for (int j = 0; j < 64; j++) begin
            w[j]  = e[j];
            wp[j] = e[j] ^ e[j+4];
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    // Called at a negedge; returns at the negedge following the block handshake.
    task automatic send_block(input logic [511:0] b, input bit keep);
        int t = 0;
        blk_valid = 1'b1;
        blk_data  = b;
        while (!blk_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!blk_ready) check("blk_ready timeout", 64'd0, 64'd1);
        @(negedge clk);
        if (!keep) begin
            blk_valid = 1'b0;
            blk_data  = {16{$urandom()}};
        end
        check("first pair valid after handshake", 64'(w_valid), 64'd1);
    endtask

    // Collects beats with w_ready asserted pct% of cycles; returns at the
    // negedge after the final beat's handshake.
    task automatic collect(input int pct, output warr_t ow, output warr_t owp, output int beats);
        bit          stalled   = 1'b0;
        bit          ready_bad = 1'b0;
        bit          idx_bad   = 1'b0;
        logic [31:0] pw = '0, pwp = '0;
        logic [5:0]  pidx = '0;
        int          cyc = 0;
        beats = 0;
        for (int j = 0; j < 64; j++) begin
            ow[j]  = '0;
            owp[j] = '0;
        end
        while (beats < 64 && cyc < 5000) begin
            if (stalled) begin
                check("stall hold w/wp", {w_j, wp_j}, {pw, pwp});
                check("stall hold valid/idx", 64'({w_valid, w_idx}), 64'({1'b1, pidx}));
            end
            w_ready = ($urandom_range(0, 99) < pct);
            if (w_valid) begin
                if (blk_ready) ready_bad = 1'b1;
                if (w_idx !== 6'(beats) || w_last !== (beats == 63)) idx_bad = 1'b1;
                stalled = !w_ready;
                pw   = w_j;
                pwp  = wp_j;
                pidx = w_idx;
                if (w_ready) begin
                    ow[beats]  = w_j;
                    owp[beats] = wp_j;
                    beats++;
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        w_ready = 1'b0;
        check("beat count", 64'(beats), 64'd64);
        check("blk_ready low in RUN", 64'(ready_bad), 64'd0);
        check("w_idx/w_last sequence", 64'(idx_bad), 64'd0);
    endtask

    task automatic cmp_seq(input string name, input logic [511:0] b, input warr_t ow, input warr_t owp);
        warr_t mw, mwp;
        int bad = -1;
        model(b, mw, mwp);
        for (int j = 0; j < 64; j++)
            if (bad < 0 && (ow[j] !== mw[j] || owp[j] !== mwp[j])) bad = j;
        if (bad < 0) bad = 0;
        check($sformatf("%s j=%0d w/wp", name, bad), {ow[bad], owp[bad]}, {mw[bad], mwp[bad]});
    endtask

    initial begin
        kat_t         kat [7];
        logic [511:0] abc, ones, a, b;
        warr_t        ow0, owp0, ow1, owp1, ow2, owp2;
        logic [31:0]  acc;
        int           n, t;

        kat[0] = '{0,  1'b1, 32'h61626380, 1'b1, 32'h61626380};
        kat[1] = '{12, 1'b1, 32'h00000000, 1'b1, 32'h9092e200};
        kat[2] = '{15, 1'b1, 32'h00000018, 1'b1, 32'h719c70f5};
        kat[3] = '{16, 1'b1, 32'h9092e200, 1'b0, 32'h0};
        kat[4] = '{17, 1'b1, 32'h00000000, 1'b0, 32'h0};
        kat[5] = '{18, 1'b1, 32'h000c0606, 1'b0, 32'h0};
        kat[6] = '{19, 1'b1, 32'h719c70ed, 1'b0, 32'h0};

        abc  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        ones = {16{32'hffffffff}};

        rst_n     = 1'b0;
        blk_valid = 1'b0;
        w_ready   = 1'b0;
        blk_data  = '0;
        #3;
        check("reset ctrl", 64'({blk_ready, w_valid, busy, w_last, w_idx}), 64'({4'b1000, 6'd0}));
        check("reset data", {w_j, wp_j}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" known-answer, no stalls
        send_block(abc, 1'b0);
        collect(100, ow0, owp0, n);
        cmp_seq("abc", abc, ow0, owp0);
        for (int k = 0; k < 7; k++) begin
            if (kat[k].chk_w)
                check($sformatf("abc W%0d", kat[k].j), 64'(ow0[kat[k].j]), 64'(kat[k].w));
            if (kat[k].chk_wp)
                check($sformatf("abc Wp%0d", kat[k].j), 64'(owp0[kat[k].j]), 64'(kat[k].wp));
        end

        // same block under 30% w_ready
        send_block(abc, 1'b0);
        collect(30, ow1, owp1, n);
        check("stalled run equals unstalled", 64'((ow1 == ow0) && (owp1 == owp0)), 64'd1);

        // back-to-back blocks with blk_valid held high
        a = rand_block();
        b = rand_block();
        send_block(a, 1'b1);
        blk_data = b;
        collect(100, ow1, owp1, n);
        cmp_seq("b2b first", a, ow1, owp1);
        check("b2b idle gap", 64'({blk_ready, w_valid}), 64'({1'b1, 1'b0}));
        @(negedge clk);
        check("b2b accept next cycle", 64'({w_valid, w_idx, w_j}), 64'({1'b1, 6'd0, b[511:480]}));
        blk_valid = 1'b0;
        blk_data  = '0;
        collect(100, ow2, owp2, n);
        cmp_seq("b2b second", b, ow2, owp2);

        // all-ones block
        send_block(ones, 1'b0);
        collect(100, ow1, owp1, n);
        cmp_seq("ones", ones, ow1, owp1);
        check("ones W16", 64'(ow1[16]), 64'h00000000ffffffff);
        acc = '0;
        for (int j = 0; j < 12; j++) acc |= owp1[j];
        check("ones Wp0..11 zero", 64'(acc), 64'd0);

        // reset in the middle of a block (j = 20)
        send_block(abc, 1'b0);
        w_ready = 1'b1;
        t = 0;
        while (w_idx != 6'd20 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reached j=20", 64'(w_idx), 64'd20);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 64'({w_valid, blk_ready, w_idx, w_j}), 64'({1'b0, 1'b1, 6'd0, 32'd0}));
        w_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a = rand_block();
        send_block(a, 1'b0);
        collect(100, ow1, owp1, n);
        cmp_seq("after reset", a, ow1, owp1);

        // random regression
        for (int k = 0; k < 200; k++) begin
            a = rand_block();
            send_block(a, 1'b0);
            collect((k % 4 == 0) ? 60 : 100, ow1, owp1, n);
            cmp_seq($sformatf("rand%0d", k), a, ow1, owp1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sm3_msg_expand.md
Name: sm3_msg_expand

Overview:
- Streaming SM3 message expander: accepts one 512-bit padded message block and transmits W_j and W'_j (j = 0..63), one pair per beat.
- The destination is the SM3 compression round datapath, which consumes one pair per round.
- Implements the expansion recurrence using the existing P1 permutation and left-rotate blocks.
- Sits between the padding/block buffer (upstream) and the compression core (downstream).

Parameters:
- None. The beat count is fixed at 64 by SM3.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- blk_valid  input  1  upstream block available
- blk_ready  output  1  expander can accept a block
- blk_data  input  512  message block, big-endian; W0 = blk_data[511:480], W15 = blk_data[31:0]
- w_valid  output  1  W/W' pair valid
- w_ready  input  1  compression core accepts pair
- w_j  output  32  W_j
- wp_j  output  32  W'_j = W_j ^ W_{j+4}
- w_idx  output  6  round index j
- w_last  output  1  high when w_idx == 63 and w_valid
- busy  output  1  block in progress (state RUN)

Behaviour:
- Storage:
  - 16-word window win[0..15] holds W_j..W_{j+15}.
  - 6-bit counter cnt holds j.
  - State register holds IDLE or RUN.
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0, win[] = 0.
  - Outputs: blk_ready = 1, w_valid = 0, w_j = 0, wp_j = 0, w_idx = 0, w_last = 0, busy = 0.
  - Release is synchronous to clk. The first active edge after release operates normally.
- Outputs are combinational from registers:
  - blk_ready = (state == IDLE)
  - w_valid = busy = (state == RUN)
  - w_j = win[0]
  - wp_j = win[0] ^ win[4]
  - w_idx = cnt
- IDLE:
  - On blk_valid && blk_ready: load win[i] = blk_data[511-32i -: 32] for i = 0..15, cnt = 0, state -> RUN.
  - Otherwise hold.
- RUN:
  - w_valid = 1.
  - On w_valid && w_ready:
    - win[i] = win[i+1] for i = 0..14.
    - win[15] = Wn, where Wn = P1(win[0] ^ win[7] ^ (win[13] <<< 15)) ^ (win[3] <<< 7) ^ win[10].
    - cnt = cnt + 1.
  - If cnt == 63 at that handshake: state -> IDLE and cnt wraps to 0.
  - Without w_ready, all outputs hold stable (AXI-style). The pair must not change while w_valid && !w_ready.
- Arithmetic:
  - All operations are 32-bit XOR/rotate; no carries.
  - P1(x) = x ^ (x <<< 15) ^ (x <<< 23).
  - The window still computes Wn after j = 51 (W68+). These values are unused and harmless.
- Latency and throughput:
  - First pair is valid in the cycle after the block handshake.
  - Sustained rate is 1 pair/cycle with w_ready held high.
  - Block-to-block: 64 beats + 1 IDLE cycle, i.e. 65 cycles minimum.
- blk_ready is low throughout RUN. blk_valid during RUN is ignored and upstream holds its data.
- Simultaneous final beat and new blk_valid: the final beat completes and the block is accepted on the next cycle (IDLE). No overlap.
- Reset mid-block: aborts immediately to the reset state. The partial sequence is discarded and not resumed.
- No X propagation: blk_data is sampled only at the handshake.

Test Plan:
- Reset check:
  - Stimulus: assert rst_n low mid-RUN (j = 20).
  - Required: within the same cycle w_valid = 0, blk_ready = 1, w_idx = 0, w_j = 0.
  - Required after release: a new block is accepted normally.
- Standard vector, "abc" padded block:
  - Stimulus: blk_data = 61626380, then 14x 00000000, then 00000018; w_ready = 1.
  - Required: j = 0: w_j = 61626380, wp_j = 61626380.
  - Required: j = 15: w_j = 00000018.
  - Required: W16 = 9092e200, W17 = 00000000, W18 = 000c0606, W19 = 719c70ed.
  - Required: j = 12: wp_j = 00000000 ^ 9092e200 = 9092e200.
  - Required: w_last is asserted only at j = 63; 64 beats total.
- Back-pressure:
  - Stimulus: same block; w_ready toggles randomly at 30% duty.
  - Required: the sequence is identical to the unstalled run.
  - Required: outputs are stable on every stalled cycle.
  - Required: total beats = 64.
- Back-to-back blocks:
  - Stimulus: blk_valid held high with two different blocks.
  - Required: second block is accepted exactly 1 cycle after the first block's w_last handshake.
  - Required: blk_ready = 0 throughout RUN.
  - Required: the second sequence matches the golden model.
- Random regression:
  - Stimulus: 200 random 512-bit blocks.
  - Required: all 64 (w_j, wp_j) pairs per block match a software SM3 expansion model.
- Edge data:
  - Stimulus: all-ones block (16x ffffffff).
  - Required: W16 = P1(0 ^ ffffffff) ^ ffffffff ^ ffffffff = ffffffff.
  - Required: wp_j = 0 for j = 0..11, and the remaining beats match the model.
